regfile_wb_ctrl: RTL and testbench
==================================

Name: regfile_wb_ctrl

Overview:
- Write-back controller and scoreboard in front of the 32x32 register file.
- Shares the register file's single write port among NUM_WB write-back requesters (ALU, load unit, multiplier, ...) using round-robin arbitration with a registered write stage.
- Tracks a busy bit per architectural register and gates instruction issue on RAW and WAW hazards.

Parameters:
- NUM_WB, 3: number of write-back requesters (2..8).
- REGFILE_SIZE, 32: number of registers; register address width is log2(REGFILE_SIZE) = 5.
- WORD_SIZE, 32: data width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- wb_valid  in  NUM_WB  per-requester write-back request.
- wb_ready  out  NUM_WB  per-requester grant; one-hot or zero; combinational.
- wb_addr  in  NUM_WB*5  destination register per requester; requester i uses bits [5i+4:5i].
- wb_data  in  NUM_WB*WORD_SIZE  write data per requester; requester i uses slice i.
- iss_valid  in  1  issue request from decode.
- iss_rs1  in  5  source register 1.
- iss_rs2  in  5  source register 2.
- iss_rd  in  5  destination register.
- iss_wr  in  1  issuing instruction writes iss_rd.
- iss_ready  out  1  no hazard; issue accepted when iss_valid & iss_ready; combinational.
- rf_w_en  out  1  register file write enable; registered.
- rf_waddr  out  32  register file write address; zero-extended from 5 bits; registered.
- rf_wdata  out  WORD_SIZE  register file write data; registered.
- busy_vec  out  REGFILE_SIZE  current scoreboard; bit 0 is always 0.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - rf_w_en=0, rf_waddr=0, rf_wdata=0.
  - busy_vec=0.
  - Round-robin pointer = NUM_WB-1, so requester 0 has highest priority on the first arbitration.
  - Reset mid-operation discards any registered write and all busy bits.
- Arbitration (combinational each cycle):
  - Search wb_valid starting at pointer+1, wrapping modulo NUM_WB.
  - The first set bit gets wb_ready; at most one grant per cycle.
  - A handshake occurs when wb_valid[i] & wb_ready[i].
  - On a handshake the pointer updates to i at the clock edge. With no request, the pointer holds.
  - Requesters must hold wb_valid, wb_addr and wb_data stable until granted.
  - wb_ready never depends on wb_ready of another cycle (no lock-up).
- Write stage (one-cycle latency):
  - A handshake at edge t registers rf_waddr and rf_wdata.
  - rf_w_en=1 during cycle t+1 only; the register file writes at edge t+1.
  - In a cycle with no handshake, rf_w_en=0; rf_waddr and rf_wdata hold their last values.
  - Back-to-back handshakes give rf_w_en high continuously; throughput is one write per cycle.
- Register 0:
  - A write-back to address 0 is granted and consumed, but rf_w_en stays 0.
  - An issue with iss_rd=0 never sets a busy bit.
  - busy_vec[0] is forced to 0.
- Scoreboard:
  - hazard = busy[iss_rs1] | busy[iss_rs2] | (iss_wr & busy[iss_rd]).
  - iss_ready = ~hazard.
  - Accepted issue with iss_wr=1 and iss_rd!=0 sets busy[iss_rd] at the edge.
  - An edge where rf_w_en=1 clears busy[rf_waddr[4:0]].
  - Same edge, same register, set and clear: set wins (the new writer is pending).
  - Same edge, different registers: both take effect.
  - The write stage is not forwarded: iss_ready depends only on registered busy_vec. A source whose write is in flight reads as busy until the edge at which rf_w_en writes it.
- Protocol errors:
  - A write-back to a register that is not busy is still written. Its busy bit stays 0.

Test Plan:
- Reset, then wb_valid=3'b111 held with addresses 5, 6, 7 -> wb_ready sequence is 001, 010, 100, 001. rf_w_en is high from cycle 2 onward, with rf_waddr 5, 6, 7, 5 one cycle after each grant.
- Issue rd=9, then issue rs1=9 -> iss_ready=0 until the edge where rf_w_en=1 with rf_waddr=9. iss_ready=1 in the next cycle, and busy_vec[9]=0.
- Issue rd=0 (iss_wr=1), then a write-back to address 0 with data 0xDEADBEEF -> busy_vec stays 0, wb_ready pulses once, rf_w_en stays 0.
- The write-back clearing register 12 and an accepted issue with rd=12 coincide at the same edge -> busy_vec[12]=1 after that edge. An issue with rd=12 in the next cycle sees iss_ready=0 (WAW).
- Requester 1 alone requests for 4 cycles, then requester 0 and requester 2 request together -> requester 2 is granted first (pointer=1), then requester 0.
- Drive rst_n=0 for one cycle while rf_w_en=1 and busy_vec=0x0000_0F00 -> next cycle rf_w_en=0, busy_vec=0, and the next arbitration favours requester 0.

Source files
------------

// File: rtl/regfile_wb_ctrl_if.sv
// Handshake bundle between the write-back requesters / decode stage and the
// register-file write-back controller.
interface regfile_wb_ctrl_if #(
    parameter int NUM_WB    = 3,
    parameter int WORD_SIZE = 32,
    parameter int AW        = 5
);
    logic [NUM_WB-1:0]           wb_valid;
    logic [NUM_WB-1:0]           wb_ready;
    logic [NUM_WB*AW-1:0]        wb_addr;
    logic [NUM_WB*WORD_SIZE-1:0] wb_data;

    logic          iss_valid;
    logic [AW-1:0] iss_rs1;
    logic [AW-1:0] iss_rs2;
    logic [AW-1:0] iss_rd;
    logic          iss_wr;
    logic          iss_ready;

    modport master (
        output wb_valid, wb_addr, wb_data,
        output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wr,
        input  wb_ready, iss_ready
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data,
        input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wr,
        output wb_ready, iss_ready
    );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Round-robin write-back arbiter with a registered register-file write stage,
// plus a per-register busy scoreboard that blocks issue on RAW/WAW hazards.
module regfile_wb_ctrl #(
    parameter int NUM_WB       = 3,
    parameter int REGFILE_SIZE = 32,
    parameter int WORD_SIZE    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    regfile_wb_ctrl_if.slave        bus,
    output logic                    rf_w_en,
    output logic [31:0]             rf_waddr,
    output logic [WORD_SIZE-1:0]    rf_wdata,
    output logic [REGFILE_SIZE-1:0] busy_vec
);
    localparam int AW    = $clog2(REGFILE_SIZE);
    localparam int PTR_W = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;

    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic                    rf_w_en_q, rf_w_en_d;
    logic [AW-1:0]           rf_waddr_q, rf_waddr_d;
    logic [WORD_SIZE-1:0]    rf_wdata_q, rf_wdata_d;
    logic [REGFILE_SIZE-1:0] busy_q, busy_d;

    logic                    grant_any;
    logic [PTR_W-1:0]        grant_idx;
    logic [AW-1:0]           grant_addr;
    logic [WORD_SIZE-1:0]    grant_data;
    logic                    hazard;
    logic                    iss_set;

    // Search starts one past the last winner, so the last winner has lowest priority.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        int idx;
        logic [PTR_W-1:0] cand;
        idx       = 0;
        cand      = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= NUM_WB; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_WB) idx = idx - NUM_WB;
            cand = PTR_W'(idx);
            if (!grant_any && bus.wb_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        bus.wb_ready = '0;
        if (grant_any) bus.wb_ready[grant_idx] = 1'b1;
    end

    assign grant_addr = bus.wb_addr[grant_idx*AW +: AW];
    assign grant_data = bus.wb_data[grant_idx*WORD_SIZE +: WORD_SIZE];

    // Register 0 is consumed like any other write-back but never written.
    always_comb begin
        ptr_d      = grant_any ? grant_idx : ptr_q;
        rf_w_en_d  = grant_any && (grant_addr != '0);
        rf_waddr_d = grant_any ? grant_addr : rf_waddr_q;
        rf_wdata_d = grant_any ? grant_data : rf_wdata_q;
    end

    // Hazards look only at registered busy bits; the in-flight write is not forwarded.
    assign hazard        = busy_q[bus.iss_rs1] | busy_q[bus.iss_rs2] |
                           (bus.iss_wr & busy_q[bus.iss_rd]);
    assign bus.iss_ready = ~hazard;
    assign iss_set       = bus.iss_valid & ~hazard & bus.iss_wr & (bus.iss_rd != '0);

    // Clear before set so a new writer to the retiring register stays pending.
    always_comb begin
        busy_d = busy_q;
        if (rf_w_en_q) busy_d[rf_waddr_q] = 1'b0;
        if (iss_set)   busy_d[bus.iss_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            ptr_q      <= PTR_W'(NUM_WB - 1);
            rf_w_en_q  <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
        end else begin
            ptr_q      <= ptr_d;
            rf_w_en_q  <= rf_w_en_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign rf_w_en  = rf_w_en_q;
    assign rf_waddr = {{(32-AW){1'b0}}, rf_waddr_q};
    assign rf_wdata = rf_wdata_q;
    assign busy_vec = busy_q;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed scenarios followed by constrained-random traffic, all checked
// against a cycle-level reference model of arbitration, write stage and scoreboard.
module tb_regfile_wb_ctrl;
    localparam int NUM_WB       = 3;
    localparam int REGFILE_SIZE = 32;
    localparam int WORD_SIZE    = 32;
    localparam int AW           = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_ctrl_if #(.NUM_WB(NUM_WB), .WORD_SIZE(WORD_SIZE), .AW(AW)) bus ();

    logic                    rf_w_en;
    logic [31:0]             rf_waddr;
    logic [WORD_SIZE-1:0]    rf_wdata;
    logic [REGFILE_SIZE-1:0] busy_vec;

    regfile_wb_ctrl #(
        .NUM_WB(NUM_WB), .REGFILE_SIZE(REGFILE_SIZE), .WORD_SIZE(WORD_SIZE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .rf_w_en(rf_w_en), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy_vec(busy_vec)
    );

    // Reference model state
    bit          m_busy [REGFILE_SIZE];
    int          m_ptr;
    bit          m_wen;
    int          m_waddr;
    logic [31:0] m_wdata;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_ready;
    logic [31:0] last_waddr;
    logic        last_iss_ready;
    logic        last_wen;
    int          last_grant;

    bit          req_on   [NUM_WB];
    int          req_addr [NUM_WB];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        for (int k = 1; k <= NUM_WB; k++) begin
            int i;
            i = (m_ptr + k) % NUM_WB;
            if (bus.wb_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] model_busy_vec();
        logic [31:0] v;
        v = '0;
        for (int r = 0; r < REGFILE_SIZE; r++) v[r] = m_busy[r];
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < REGFILE_SIZE; r++) m_busy[r] = 1'b0;
        m_ptr = NUM_WB - 1;
        m_wen = 1'b0;
        m_waddr = 0;
        m_wdata = '0;
    endtask

    task automatic drive_req(input int i, input bit on, input int addr, input logic [31:0] data);
        bus.wb_valid[i] = on;
        bus.wb_addr[i*AW +: AW] = AW'(addr);
        bus.wb_data[i*WORD_SIZE +: WORD_SIZE] = data;
    endtask

    task automatic drive_iss(input bit v, input int rs1, input int rs2, input int rd, input bit wr);
        bus.iss_valid = v;
        bus.iss_rs1 = AW'(rs1);
        bus.iss_rs2 = AW'(rs2);
        bus.iss_rd = AW'(rd);
        bus.iss_wr = wr;
    endtask

    // One clock: check everything at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        int g;
        int a;
        bit hz;
        logic [31:0] exp_rdy;
        @(negedge clk);
        g = model_grant();
        exp_rdy = (g >= 0) ? (32'd1 << g) : 32'd0;
        hz = m_busy[bus.iss_rs1] | m_busy[bus.iss_rs2] | (bus.iss_wr & m_busy[bus.iss_rd]);
        last_ready     = 32'(bus.wb_ready);
        last_iss_ready = bus.iss_ready;
        last_wen       = rf_w_en;
        last_waddr     = rf_waddr;
        check("wb_ready", last_ready, exp_rdy);
        check("iss_ready", 32'(bus.iss_ready), 32'(!hz));
        check("rf_w_en", 32'(rf_w_en), 32'(m_wen));
        check("rf_waddr", rf_waddr, 32'(m_waddr));
        check("rf_wdata", rf_wdata, m_wdata);
        check("busy_vec", busy_vec, model_busy_vec());
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (m_wen) m_busy[m_waddr] = 1'b0;
            if (bus.iss_valid && !hz && bus.iss_wr && bus.iss_rd != 0) m_busy[bus.iss_rd] = 1'b1;
            if (g >= 0) begin
                a = int'(bus.wb_addr[g*AW +: AW]);
                m_wen   = (a != 0);
                m_waddr = a;
                m_wdata = bus.wb_data[g*WORD_SIZE +: WORD_SIZE];
                m_ptr   = g;
            end else begin
                m_wen = 1'b0;
            end
        end
        last_grant = g;
        #1;
    endtask

    initial begin
        logic [31:0] exp_rdy_seq  [4];
        logic [31:0] exp_addr_seq [4];
        int busy_list [$];

        bus.wb_valid = '0;
        bus.wb_addr  = '0;
        bus.wb_data  = '0;
        drive_iss(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        cycle();

        // Reset state
        check("rst_w_en", 32'(rf_w_en), 32'd0);
        check("rst_waddr", rf_waddr, 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        check("rst_busy", busy_vec, 32'd0);
        rst_n = 1'b1;

        // All three requesters held: rotation 0,1,2,0
        exp_rdy_seq  = '{32'd1, 32'd2, 32'd4, 32'd1};
        exp_addr_seq = '{32'd5, 32'd6, 32'd7, 32'd5};
        drive_req(0, 1, 5, 32'h0000_0A05);
        drive_req(1, 1, 6, 32'h0000_0B06);
        drive_req(2, 1, 7, 32'h0000_0C07);
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("rr_ready", last_ready, exp_rdy_seq[k]);
            check("rr_w_en", 32'(rf_w_en), 32'd1);
            check("rr_waddr", rf_waddr, exp_addr_seq[k]);
        end
        bus.wb_valid = '0;
        cycle();
        cycle();

        // RAW: rd=9 then rs1=9 stalls until the write of 9 retires
        drive_iss(1, 0, 0, 9, 1);
        cycle();
        check("raw_issue_rd", 32'(last_iss_ready), 32'd1);
        check("raw_busy9_set", 32'(busy_vec[9]), 32'd1);
        drive_iss(1, 9, 0, 0, 0);
        cycle();
        check("raw_stall0", 32'(last_iss_ready), 32'd0);
        drive_req(1, 1, 9, 32'h1234_5678);
        cycle();
        check("raw_stall1", 32'(last_iss_ready), 32'd0);
        drive_req(1, 0, 0, 32'd0);
        cycle();
        check("raw_stall_inflight", 32'(last_iss_ready), 32'd0);
        check("raw_wen", 32'(last_wen), 32'd1);
        check("raw_waddr", last_waddr, 32'd9);
        check("raw_busy9_clr", 32'(busy_vec[9]), 32'd0);
        cycle();
        check("raw_release", 32'(last_iss_ready), 32'd1);
        drive_iss(0, 0, 0, 0, 0);

        // Register 0: never busy, write-back consumed but not written
        drive_iss(1, 0, 0, 0, 1);
        cycle();
        check("r0_busy", busy_vec, 32'd0);
        drive_iss(0, 0, 0, 0, 0);
        drive_req(0, 1, 0, 32'hDEAD_BEEF);
        cycle();
        check("r0_ready", last_ready, 32'd1);
        drive_req(0, 0, 0, 32'd0);
        cycle();
        check("r0_ready_once", last_ready, 32'd0);
        check("r0_no_wen", 32'(last_wen), 32'd0);
        cycle();
        check("r0_busy_after", busy_vec, 32'd0);

        // Set and clear of register 12 at the same edge: set wins
        drive_req(2, 1, 12, 32'h0000_0012);
        cycle();
        drive_req(2, 0, 0, 32'd0);
        drive_iss(1, 0, 0, 12, 1);
        cycle();
        check("sc_wen", 32'(last_wen), 32'd1);
        check("sc_waddr", last_waddr, 32'd12);
        check("sc_accept", 32'(last_iss_ready), 32'd1);
        check("sc_busy12", 32'(busy_vec[12]), 32'd1);
        cycle();
        check("sc_waw", 32'(last_iss_ready), 32'd0);
        drive_iss(0, 0, 0, 0, 0);
        drive_req(2, 1, 12, 32'h0000_1212);
        cycle();
        drive_req(2, 0, 0, 32'd0);
        cycle();
        cycle();
        check("sc_cleared", busy_vec, 32'd0);

        // Pointer after a lone requester 1: requester 2 before requester 0
        drive_req(1, 1, 1, 32'h0000_0111);
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("ptr_lone1", last_ready, 32'd2);
        end
        drive_req(1, 0, 0, 32'd0);
        drive_req(0, 1, 2, 32'h0000_0222);
        drive_req(2, 1, 3, 32'h0000_0333);
        cycle();
        check("ptr_first2", last_ready, 32'd4);
        drive_req(2, 0, 0, 32'd0);
        cycle();
        check("ptr_then0", last_ready, 32'd1);
        drive_req(0, 0, 0, 32'd0);
        cycle();
        cycle();

        // Reset mid-operation with writes in flight and registers 8..11 busy
        for (int r = 8; r < 12; r++) begin
            drive_iss(1, 0, 0, r, 1);
            cycle();
        end
        drive_iss(0, 0, 0, 0, 0);
        drive_req(0, 1, 3, 32'h0000_0303);
        cycle();
        drive_req(0, 0, 0, 32'd0);
        check("mr_busy_pre", busy_vec, 32'h0000_0F00);
        check("mr_wen_pre", 32'(rf_w_en), 32'd1);
        rst_n = 1'b0;
        cycle();
        check("mr_wen", 32'(rf_w_en), 32'd0);
        check("mr_busy", busy_vec, 32'd0);
        rst_n = 1'b1;
        bus.wb_valid = 3'b111;
        cycle();
        check("mr_prio0", last_ready, 32'd1);
        bus.wb_valid = '0;
        cycle();
        cycle();

        // Random traffic; requesters hold until granted, write-backs mostly target busy registers
        for (int i = 0; i < NUM_WB; i++) req_on[i] = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (last_grant >= 0) req_on[last_grant] = 1'b0;
            for (int i = 0; i < NUM_WB; i++) begin
                if (!req_on[i] && $urandom_range(0, 2) == 0) begin
                    busy_list.delete();
                    for (int r = 1; r < 16; r++) if (m_busy[r]) busy_list.push_back(r);
                    if (busy_list.size() > 0 && $urandom_range(0, 3) != 0)
                        req_addr[i] = busy_list[$urandom_range(0, busy_list.size() - 1)];
                    else
                        req_addr[i] = int'($urandom_range(0, 15));
                    req_on[i] = 1'b1;
                    drive_req(i, 1, req_addr[i], $urandom);
                end else if (!req_on[i]) begin
                    drive_req(i, 0, 0, 32'd0);
                end
            end
            drive_iss($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15),
                      $urandom_range(0, 15), $urandom_range(0, 1));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
